// File: rtl/sentinel_pkg.sv
// Sentinel shared types: lock telemetry encodings,
// telemetry classes and the key presenter state set.
package sentinel_pkg;

  localparam logic [7:0] SEG_LOCKED   = 8'hC7;
  localparam logic [7:0] SEG_UNLOCKED = 8'hC1;
  localparam logic [7:0] SEG_OFF      = 8'hFF;
  localparam logic [7:0] GLOW_ON      = 8'hFF;
  localparam logic [7:0] GLOW_OFF     = 8'h00;

  typedef enum logic [1:0] {
    TEL_LOCKED,
    TEL_UNLOCKED,
    TEL_DARK,
    TEL_ILLEGAL
  } tele_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_CONFIRM,
    ST_RELEASE,
    ST_BACKOFF,
    ST_SUCCESS,
    ST_DENY,
    ST_FAULT
  } state_e;

  function automatic tele_e classify(
    input logic [7:0] seg,
    input logic [7:0] glow
  );
    tele_e c;
    unique case (1'b1)
      (seg == SEG_LOCKED && glow == GLOW_OFF):
        c = TEL_LOCKED;
      (seg == SEG_UNLOCKED && glow == GLOW_ON):
        c = TEL_UNLOCKED;
      (seg == SEG_OFF && glow == GLOW_OFF):
        c = TEL_DARK;
      default:
        c = TEL_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sentinel_key_presenter_if.sv
// Lock-facing bus: key drive out, 7-seg and
// glow readback in.
interface sentinel_key_presenter_if;

  logic [7:0] key_out;
  logic [7:0] seg_in;
  logic [7:0] glow_in;

  modport master (
    output key_out,
    input  seg_in,
    input  glow_in
  );

  modport slave (
    input  key_out,
    output seg_in,
    output glow_in
  );

endinterface

// File: rtl/sentinel_status_classifier.sv
// Registers the lock readback once and decodes
// it into a telemetry class.
module sentinel_status_classifier
  import sentinel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic [7:0] glow_in,
  output tele_e      cls
);

  logic [7:0] seg_q;
  logic [7:0] glow_q;

  // one sample stage; reset value reads as dark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= SEG_OFF;
      glow_q <= GLOW_OFF;
    end else begin
      seg_q  <= seg_in;
      glow_q <= glow_in;
    end
  end

  assign cls = classify(seg_q, glow_q);

endmodule

// File: rtl/sentinel_key_presenter.sv
// Sentinel key presenter: drives the key, confirms
// unlock, removes key, confirms relock, retries.
module sentinel_key_presenter
  import sentinel_pkg::*;
#(
  parameter logic [7:0] KEY            = 8'hB6,
  parameter logic [7:0] IDLE_PATTERN   = 8'h00,
  parameter int         RESP_TIMEOUT   = 16,
  parameter int         HOLD_CYCLES    = 4,
  parameter int         BACKOFF_CYCLES = 8,
  parameter int         MAX_ATTEMPTS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       clear,
  sentinel_key_presenter_if.master lock,
  output logic       busy,
  output logic       done,
  output logic       granted,
  output logic       denied,
  output logic       fault,
  output logic [3:0] attempts
);

  localparam int TMAX =
    (RESP_TIMEOUT > BACKOFF_CYCLES) ?
    RESP_TIMEOUT : BACKOFF_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [TW-1:0] T_RESP =
    TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] T_BACK =
    TW'(BACKOFF_CYCLES - 1);
  localparam logic [HW-1:0] H_DONE =
    HW'(HOLD_CYCLES);
  localparam logic [3:0] A_MAX =
    4'(MAX_ATTEMPTS);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] hold_inc;
  logic [3:0]    att_q, att_d;
  logic          done_q, done_d;
  logic          gr_q, gr_d;
  logic          dn_q, dn_d;
  logic          flt_q, flt_d;
  logic          busy_w;
  tele_e         cls;

  sentinel_status_classifier u_cls (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_in  (lock.seg_in),
    .glow_in (lock.glow_in),
    .cls     (cls)
  );

  assign busy_w =
    (state_q == ST_PRESENT) ||
    (state_q == ST_CONFIRM) ||
    (state_q == ST_RELEASE) ||
    (state_q == ST_BACKOFF);

  assign hold_inc =
    (hold_q == '1) ? hold_q : hold_q + 1'b1;

  // state, counters and sticky status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      att_q   <= '0;
      done_q  <= 1'b0;
      gr_q    <= 1'b0;
      dn_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      att_q   <= att_d;
      done_q  <= done_d;
      gr_q    <= gr_d;
      dn_q    <= dn_d;
      flt_q   <= flt_d;
    end
  end

  // next-state; status flags rise with done
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    att_d   = att_q;
    done_d  = 1'b0;
    gr_d    = gr_q;
    dn_d    = dn_q;
    flt_d   = flt_q;
    if (clear) begin
      gr_d  = 1'b0;
      dn_d  = 1'b0;
      flt_d = 1'b0;
    end
    if (busy_w && !ena) begin
      state_d = ST_IDLE;
    end else if (busy_w && cls == TEL_ILLEGAL) begin
      state_d = ST_FAULT;
      flt_d   = 1'b1;
      done_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && ena && (!flt_q || clear)) begin
            state_d = ST_PRESENT;
            gr_d    = 1'b0;
            dn_d    = 1'b0;
            att_d   = 4'd1;
            timer_d = '0;
            hold_d  = '0;
          end
        end
        ST_PRESENT: begin
          if (cls == TEL_UNLOCKED) begin
            state_d = ST_CONFIRM;
            hold_d  = HW'(1);
          end else if (timer_q == T_RESP) begin
            state_d = ST_BACKOFF;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (cls == TEL_UNLOCKED) begin
            hold_d = hold_inc;
            if (hold_inc >= H_DONE) begin
              state_d = ST_RELEASE;
              timer_d = '0;
            end
          end else begin
            state_d = ST_BACKOFF;
            timer_d = '0;
          end
        end
        ST_RELEASE: begin
          if (cls == TEL_LOCKED) begin
            state_d = ST_SUCCESS;
            gr_d    = 1'b1;
            done_d  = 1'b1;
          end else if (timer_q == T_RESP) begin
            state_d = ST_FAULT;
            flt_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (timer_q != T_BACK) begin
            timer_d = timer_q + 1'b1;
          end else if (att_q >= A_MAX) begin
            state_d = ST_DENY;
            dn_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PRESENT;
            att_d   = att_q + 4'd1;
            timer_d = '0;
          end
        end
        ST_SUCCESS,
        ST_DENY: begin
          state_d = ST_IDLE;
        end
        ST_FAULT: begin
          if (clear) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign lock.key_out =
    (state_q == ST_PRESENT ||
     state_q == ST_CONFIRM) ? KEY : IDLE_PATTERN;

  assign busy     = busy_w;
  assign done     = done_q;
  assign granted  = gr_q;
  assign denied   = dn_q;
  assign fault    = flt_q;
  assign attempts = att_q;

endmodule

// File: tb/tb_sentinel_key_presenter.sv
// Bench for sentinel_key_presenter: behavioural
// lock model, vector table and scoreboard queue.
module tb_sentinel_key_presenter;

  localparam int M_NORMAL = 0;
  localparam int M_WRONG  = 1;
  localparam int M_DROP   = 2;
  localparam int M_PANIC  = 3;
  localparam int M_STUCK  = 4;

  typedef struct {
    int         mode;
    logic [7:0] lkey;
    int         lat;
    logic       g;
    logic       d;
    logic       f;
    logic [3:0] att;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       busy, done, granted, denied, fault;
  logic [3:0] attempts;

  int         n_vec = 0;
  int         n_err = 0;

  int         mode = M_NORMAL;
  logic [7:0] lock_key = 8'hB6;
  logic [7:0] lk_seg, lk_glow;
  int         unl_cnt, kp_cnt;
  logic       drop_armed, dropped, stuck;

  vec_t       vecs [5];
  vec_t       exp_q [$];

  sentinel_key_presenter_if bus ();

  sentinel_key_presenter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .clear    (clear),
    .lock     (bus),
    .busy     (busy),
    .done     (done),
    .granted  (granted),
    .denied   (denied),
    .fault    (fault),
    .attempts (attempts)
  );

  always #5 clk = ~clk;

  assign bus.seg_in  = lk_seg;
  assign bus.glow_in = lk_glow;

  // lock model: one-cycle registered response
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_seg     <= 8'hC7;
      lk_glow    <= 8'h00;
      unl_cnt    <= 0;
      kp_cnt     <= 0;
      drop_armed <= 1'b1;
      dropped    <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      if (bus.key_out == 8'hB6)
        kp_cnt <= kp_cnt + 1;
      if (mode == M_PANIC && kp_cnt >= 4) begin
        lk_seg  <= 8'h5A;
        lk_glow <= 8'h00;
      end else if (stuck) begin
        lk_seg  <= 8'hC1;
        lk_glow <= 8'hFF;
      end else if (bus.key_out == lock_key) begin
        if (mode == M_DROP && drop_armed &&
            unl_cnt >= 2) begin
          lk_seg  <= 8'hC7;
          lk_glow <= 8'h00;
          dropped <= 1'b1;
        end else begin
          lk_seg  <= 8'hC1;
          lk_glow <= 8'hFF;
          unl_cnt <= unl_cnt + 1;
          if (mode == M_STUCK)
            stuck <= 1'b1;
        end
      end else begin
        lk_seg  <= 8'hC7;
        lk_glow <= 8'h00;
        if (dropped)
          drop_armed <= 1'b0;
      end
    end
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    clear = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    vec_t e;
    int   cyc;
    logic got;

    vecs[0] = '{M_NORMAL, 8'hB6, 10,
                1'b1, 1'b0, 1'b0, 4'd1};
    vecs[1] = '{M_WRONG,  8'hB7, 73,
                1'b0, 1'b1, 1'b0, 4'd3};
    vecs[2] = '{M_DROP,   8'hB6, 23,
                1'b1, 1'b0, 1'b0, 4'd2};
    vecs[3] = '{M_PANIC,  8'hB7, 8,
                1'b0, 1'b0, 1'b1, 4'd1};
    vecs[4] = '{M_STUCK,  8'hB6, 23,
                1'b0, 1'b0, 1'b1, 4'd1};

    #1;
    chk("rst_key", bus.key_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_granted", granted, 1'b0);
    chk("rst_denied", denied, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_attempts", attempts, 4'd0);

    foreach (vecs[i]) begin
      mode     = vecs[i].mode;
      lock_key = vecs[i].lkey;
      do_reset();
      start = 1'b1;
      exp_q.push_back(vecs[i]);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
        step();
        start = 1'b0;
        cyc++;
        if (cyc == 1) begin
          chk("key_presented", bus.key_out, 8'hB6);
          chk("busy_started", busy, 1'b1);
        end
        if (done)
          got = 1'b1;
      end
      e = exp_q.pop_front();
      chk("done_seen", got, 1'b1);
      chk("latency", cyc, e.lat);
      chk("granted", granted, e.g);
      chk("denied", denied, e.d);
      chk("fault", fault, e.f);
      chk("attempts", attempts, e.att);
      chk("key_idle_end", bus.key_out, 8'h00);
      step();
      chk("done_pulse", done, 1'b0);
      chk("sticky", {granted, denied, fault},
          {e.g, e.d, e.f});
      chk("idle_busy", busy, 1'b0);
      if (e.f) begin
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("fault_blocks_start", busy, 1'b0);
        chk("fault_held", fault, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_fault", fault, 1'b0);
        chk("clear_busy", busy, 1'b0);
      end
    end

    mode     = M_NORMAL;
    lock_key = 8'hB6;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("confirm_busy", busy, 1'b1);
    chk("confirm_key", bus.key_out, 8'hB6);
    ena = 1'b0;
    step();
    chk("abort_busy", busy, 1'b0);
    chk("abort_key", bus.key_out, 8'h00);
    chk("abort_done", done, 1'b0);
    chk("abort_attempts", attempts, 4'd1);
    step();
    step();
    chk("abort_no_done", done, 1'b0);
    chk("abort_granted", granted, 1'b0);
    ena = 1'b1;

    mode     = M_WRONG;
    lock_key = 8'hB7;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 19; k++)
      step();
    chk("backoff_busy", busy, 1'b1);
    chk("backoff_key", bus.key_out, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_attempts", attempts, 4'd0);
    chk("arst_key", bus.key_out, 8'h00);
    chk("arst_flags",
        {done, granted, denied, fault}, 4'b0000);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
